// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch controller
//
// Contents:
//   INSTR_BYTES         - PC increment per sequential fetch
//   DEFAULT_BOOT_ADDR   - PC loaded by reset
//   DEFAULT_EXC_VECTOR  - exception redirect target (FETCH_CTRL_EXC_EN builds)
//   fetch_state_e       - fetch sequencer states
package fetch_pkg;

    localparam int          INSTR_BYTES        = 4;
    localparam logic [31:0] DEFAULT_BOOT_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - instruction-memory and decode handshake bundle
//
// Signals:
//   imem_req_valid / imem_req_addr / imem_req_ready  - fetch request channel
//   imem_rsp_valid / imem_rsp_data                    - in-order fetch response
//   dec_valid / dec_pc / dec_instr / dec_ready        - instruction to decode
// Modports:
//   master - the fetch controller
//   slave  - memory and decode side
interface fetch_controller_if #(
    parameter int XLEN = 32
);

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
    logic            dec_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output dec_valid,
        output dec_pc,
        output dec_instr,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  dec_valid,
        input  dec_pc,
        input  dec_instr,
        output dec_ready
    );

endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next fetch PC select
//
// Ports:
//   reset         in   load BOOT_ADDR
//   exc_take      in   redirect to EXC_VECTOR (highest after reset)
//   branch_take   in   redirect to branch_target with [1:0] cleared
//   incr          in   advance by one instruction
//   pc            in   current fetch PC
//   branch_target in   raw redirect address
//   next_pc       out  PC value for the next edge (holds pc otherwise)
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR  = XLEN'(DEFAULT_BOOT_ADDR),
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR)
) (
    input  logic            reset,
    input  logic            exc_take,
    input  logic            branch_take,
    input  logic            incr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc
);

    // Clears the byte-offset bits so every fetch address is word aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    always_comb begin
        next_pc = pc;
        if (reset) begin
            next_pc = BOOT_ADDR;
        end else if (exc_take) begin
            next_pc = EXC_VECTOR & ALIGN_MASK;
        end else if (branch_take) begin
            next_pc = branch_target & ALIGN_MASK;
        end else if (incr) begin
            // Natural modulo-2^XLEN wrap of the adder.
            next_pc = pc + XLEN'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with redirect and stale-response drop
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   branch        in   one-cycle redirect pulse from execute
//   branch_target in   redirect address, bits [1:0] ignored
//   exc_valid     in   exception redirect to EXC_VECTOR (FETCH_CTRL_EXC_EN only)
//   exc_taken     out  pulses the cycle after an accepted exception (FETCH_CTRL_EXC_EN only)
//   pc_out        out  current fetch PC
//   bus           master side of fetch_controller_if (imem request/response, decode)
//
// Optional feature macro: FETCH_CTRL_EXC_EN
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR  = XLEN'(DEFAULT_BOOT_ADDR),
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
`ifdef FETCH_CTRL_EXC_EN
    input  logic            exc_valid,
    output logic            exc_taken,
`endif
    output logic [XLEN-1:0] pc_out,
    fetch_controller_if.master bus
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic            active;
    logic            exc_take;
    logic            branch_take;
    logic            redirect;
    logic            pc_incr;
    logic            capture;
    logic [XLEN-1:0] pc_next;

    // Redirects are ignored in IDLE; an exception outranks a same-cycle branch.
    assign active = (state != ST_IDLE);
`ifdef FETCH_CTRL_EXC_EN
    assign exc_take = active & exc_valid;
`else
    assign exc_take = 1'b0;
`endif
    assign branch_take = active & branch & ~exc_take;
    assign redirect    = exc_take | branch_take;

    // The PC only advances when a request is accepted without a redirect.
    assign pc_incr = (state == ST_REQ) & bus.imem_req_ready & ~redirect;

    // A response arriving in WAIT alongside a redirect is discarded.
    assign capture = (state == ST_WAIT) & bus.imem_rsp_valid & ~redirect;

    fetch_next_pc #(
        .XLEN       (XLEN),
        .BOOT_ADDR  (BOOT_ADDR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .reset         (reset),
        .exc_take      (exc_take),
        .branch_take   (branch_take),
        .incr          (pc_incr),
        .pc            (pc_out),
        .branch_target (branch_target),
        .next_pc       (pc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DROP is entered whenever a redirect leaves a response
    // still owed, so the stale word is swallowed before the next request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    state_next = bus.imem_req_ready ? ST_DROP : ST_REQ;
                end else if (bus.imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_next = redirect ? ST_REQ : ST_HOLD;
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end
            ST_HOLD: begin
                // A redirect squashes the held instruction even if decode is ready.
                if (redirect || bus.dec_ready) begin
                    state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic. dec_valid is exactly "in HOLD": HOLD is entered only with
    // a captured instruction and left on consume or redirect.
    always_comb begin
        bus.imem_req_valid = (state == ST_REQ);
        bus.imem_req_addr  = pc_out;
        bus.dec_valid      = (state == ST_HOLD);
    end

    // PC and decode payload registers
    always_ff @(posedge clk) begin
        pc_out <= pc_next;
        if (reset) begin
            bus.dec_pc    <= '0;
            bus.dec_instr <= '0;
        end else if (capture) begin
            // pc_out already advanced past the issued address at acceptance.
            bus.dec_pc    <= pc_out - XLEN'(INSTR_BYTES);
            bus.dec_instr <= bus.imem_rsp_data;
        end
    end

`ifdef FETCH_CTRL_EXC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_taken <= 1'b0;
        end else begin
            exc_taken <= exc_take;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [31:0] EXC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic        exc_in;
`ifdef FETCH_CTRL_EXC_EN
    logic        exc_taken;
`endif

    always #5 clk = ~clk;

    fetch_controller_if #(.XLEN(32)) bus ();

    fetch_controller #(
        .XLEN       (32),
        .BOOT_ADDR  (BOOT),
        .EXC_VECTOR (EXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch        (branch),
        .branch_target (branch_target),
`ifdef FETCH_CTRL_EXC_EN
        .exc_valid     (exc_in),
        .exc_taken     (exc_taken),
`endif
        .pc_out        (pc_out),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: one pending word, returned lat cycles after the one
    // mandatory cycle following acceptance.
    logic        mem_pending = 1'b0;
    int          mem_wait    = 0;
    logic [31:0] mem_addr    = '0;
    int          lat         = 0;

    // Reference model: address of the next accepted request and of the next
    // consumed instruction in program order.
    logic [31:0] exp_fetch = BOOT;
    logic [31:0] exp_next  = BOOT;
    int          consumed  = 0;
    int          cyc       = 0;

    logic        prev_hold     = 1'b0;
    logic        prev_req_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr, prev_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive memory response, check against the model, advance.
    task automatic cycle();
        logic        accept, consume, redir;
        logic [31:0] tgt;
        bus.imem_rsp_valid = mem_pending && (mem_wait == 0);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        accept  = !reset && bus.imem_req_valid && bus.imem_req_ready;
        redir   = branch || exc_in;
        consume = bus.dec_valid && bus.dec_ready && !redir;
        tgt     = exc_in ? EXC : (branch_target & ~32'h3);
        if (!reset) begin
            if (bus.imem_req_valid) begin
                chk("req_addr_is_pc", bus.imem_req_addr, pc_out);
                chk("one_outstanding", 32'(mem_pending), 0);
            end
            if (accept) chk("fetch_addr", bus.imem_req_addr, exp_fetch);
            if (consume) begin
                chk("dec_pc_order", bus.dec_pc, exp_next);
                chk("dec_instr_data", bus.dec_instr, instr_of(bus.dec_pc));
                consumed++;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.dec_valid), 1);
                chk("hold_pc", bus.dec_pc, prev_pc);
                chk("hold_instr", bus.dec_instr, prev_instr);
            end
            if (prev_req_hold) begin
                chk("req_stable_valid", 32'(bus.imem_req_valid), 1);
                chk("req_stable_addr", bus.imem_req_addr, prev_addr);
            end
        end
        if (reset) begin
            exp_fetch = BOOT;
            exp_next  = BOOT;
        end else if (redir) begin
            exp_fetch = tgt;
            exp_next  = tgt;
        end else begin
            if (accept)  exp_fetch = exp_fetch + 32'd4;
            if (consume) exp_next  = exp_next + 32'd4;
        end
        if (bus.imem_rsp_valid) mem_pending = 1'b0;
        else if (mem_pending && mem_wait > 0) mem_wait--;
        if (accept) begin
            mem_pending = 1'b1;
            mem_wait    = lat;
            mem_addr    = bus.imem_req_addr;
        end
        prev_hold     = !reset && !redir && bus.dec_valid && !bus.dec_ready;
        prev_req_hold = !reset && !redir && bus.imem_req_valid && !bus.imem_req_ready;
        prev_pc       = bus.dec_pc;
        prev_instr    = bus.dec_instr;
        prev_addr     = bus.imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_dec(input string tag);
        int n = 0;
        while (!bus.dec_valid && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_dec_wait"}, 32'(bus.dec_valid), 1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.imem_req_valid && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_req_wait"}, 32'(bus.imem_req_valid), 1);
    endtask

    logic [31:0] seen_pc [4];
    int          seen_cyc[4];
    int          n_seen;
    logic [31:0] held;

    initial begin
        reset              = 1'b1;
        branch             = 1'b0;
        branch_target      = '0;
        exc_in             = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;

        // Reset values
        cycle();
        cycle();
        chk("rst_pc", pc_out, BOOT);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 0);
        chk("rst_dec_pc", bus.dec_pc, 0);
        chk("rst_dec_instr", bus.dec_instr, 0);

        // Release, zero-wait memory, decode always ready
        reset = 1'b0;
        lat   = 0;
        cycle();
        chk("e0_req_valid", 32'(bus.imem_req_valid), 1);
        chk("e0_req_addr", bus.imem_req_addr, BOOT);
        n_seen = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (bus.dec_valid && n_seen < 4) begin
                seen_pc[n_seen]  = bus.dec_pc;
                seen_cyc[n_seen] = cyc;
                n_seen++;
            end
        end
        chk("stream_count", n_seen, 3);
        if (n_seen >= 3) begin
            chk("stream_pc0", seen_pc[0], 32'h1000);
            chk("stream_pc1", seen_pc[1], 32'h1004);
            chk("stream_pc2", seen_pc[2], 32'h1008);
            chk("stream_gap01", seen_cyc[1] - seen_cyc[0], 3);
            chk("stream_gap12", seen_cyc[2] - seen_cyc[1], 3);
        end

        // Decode stalls for 5 cycles in HOLD
        bus.dec_ready = 1'b0;
        wait_dec("stall");
        chk("stall_pc", bus.dec_pc, 32'h100C);
        held = bus.dec_instr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", 32'(bus.dec_valid), 1);
            chk("stall_instr", bus.dec_instr, held);
            chk("stall_no_req", 32'(bus.imem_req_valid), 0);
        end
        bus.dec_ready = 1'b1;
        cycle();

        // Branch in WAIT, stale response two cycles later
        lat = 2;
        wait_req("wbr");
        cycle();
        chk("wbr_in_wait", 32'(bus.imem_req_valid), 0);
        branch        = 1'b1;
        branch_target = 32'h0000_2003;
        cycle();
        branch = 1'b0;
        chk("wbr_pc", pc_out, 32'h2000);
        chk("wbr_no_req", 32'(bus.imem_req_valid), 0);
        wait_req("wbr_next");
        chk("wbr_next_addr", bus.imem_req_addr, 32'h2000);
        wait_dec("wbr_first");
        chk("wbr_first_pc", bus.dec_pc, 32'h2000);
        chk("wbr_first_instr", bus.dec_instr, instr_of(32'h2000));

        // Branch in HOLD with decode ready in the same cycle
        lat           = 0;
        branch        = 1'b1;
        branch_target = 32'h0000_4000;
        cycle();
        branch = 1'b0;
        chk("hbr_squash", 32'(bus.dec_valid), 0);
        chk("hbr_req_valid", 32'(bus.imem_req_valid), 1);
        chk("hbr_req_addr", bus.imem_req_addr, 32'h4000);

        // Wrap at the top of the address space (unaligned target masked)
        bus.imem_req_ready = 1'b0;
        branch             = 1'b1;
        branch_target      = 32'hFFFF_FFFF;
        cycle();
        branch = 1'b0;
        chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        cycle();
        chk("wrap_pc_zero", pc_out, 32'h0);
        wait_dec("wrap");
        chk("wrap_dec_pc", bus.dec_pc, 32'hFFFF_FFFC);
        cycle();
        wait_req("wrap_next");
        chk("wrap_next_addr", bus.imem_req_addr, 32'h0);

        // Reset in WAIT with a stale response on the following cycle
        lat = 1;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rw_pc", pc_out, BOOT);
        chk("rw_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rw_dec_valid", 32'(bus.dec_valid), 0);
        chk("rw_dec_pc", bus.dec_pc, 0);
        chk("rw_dec_instr", bus.dec_instr, 0);
        reset = 1'b0;
        cycle();
        chk("rw_stale_dec_valid", 32'(bus.dec_valid), 0);
        chk("rw_stale_dec_instr", bus.dec_instr, 0);
        chk("rw_req_addr", bus.imem_req_addr, BOOT);
        wait_dec("rw");
        chk("rw_first_pc", bus.dec_pc, BOOT);
        chk("rw_first_instr", bus.dec_instr, instr_of(BOOT));

`ifdef FETCH_CTRL_EXC_EN
        // Exception and branch together: exception wins
        cycle();
        wait_req("exc");
        bus.imem_req_ready = 1'b0;
        exc_in             = 1'b1;
        branch             = 1'b1;
        branch_target      = 32'h0000_3000;
        cycle();
        exc_in = 1'b0;
        branch = 1'b0;
        chk("exc_taken_pulse", 32'(exc_taken), 1);
        chk("exc_req_addr", bus.imem_req_addr, EXC);
        bus.imem_req_ready = 1'b1;
        cycle();
        chk("exc_taken_clear", 32'(exc_taken), 0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.dec_ready      = ($urandom_range(0, 9) < 7);
            branch             = ($urandom_range(0, 15) == 0);
            branch_target      = $urandom;
            lat                = $urandom_range(0, 3);
            cycle();
        end
        branch = 1'b0;
        chk("liveness", 32'(consumed > 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the core: owns the fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and presents each returned instruction with its PC to decode. It applies branch redirects from execute and discards stale responses. It replaces free-running PC increment with memory- and decode-aware sequencing.

## Interface
- `XLEN`, 32: address and instruction width.
- `BOOT_ADDR`, 32'h0000_1000: PC value loaded by reset.
- `EXC_VECTOR`, 32'h0000_0100: exception redirect target. Used only with `FETCH_CTRL_EXC_EN`.

- `clk`  in  1  system clock. This block has one clock; all state changes on the rising edge.
- `reset`  in  1  reset. Synchronous, active-high.
- `branch`  in  1  redirect pulse from execute, one cycle wide.
- `branch_target`  in  XLEN  redirect address. Bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  XLEN  fetch address. Equals `pc_out` while `imem_req_valid` is high.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response data valid. Arrives at least 1 cycle after acceptance, in order.
- `imem_rsp_data`  in  XLEN  instruction word.
- `dec_valid`  out  1  instruction available to decode.
- `dec_pc`  out  XLEN  PC of the presented instruction.
- `dec_instr`  out  XLEN  presented instruction.
- `dec_ready`  in  1  decode consumes.
- `pc_out`  out  XLEN  current fetch PC.

## Operation
- The block is a state machine with five states: IDLE, REQ, WAIT, HOLD, DROP. At most one request is outstanding at any time.
- **Reset values:** state=IDLE; `pc_out`=BOOT_ADDR; `imem_req_valid`=0; `dec_valid`=0; `dec_pc`=0; `dec_instr`=0.
- **IDLE:**
  - Moves to REQ on the first edge with `reset` low.
- **REQ:**
  - `imem_req_valid`=1.
  - On `imem_req_valid & imem_req_ready`: `pc_out`<=`pc_out`+4, then go to WAIT.
- **WAIT:**
  - On `imem_rsp_valid`: `dec_instr`<=data and `dec_pc`<=the address that was issued (`pc_out`-4). Set `dec_valid`=1 and go to HOLD.
- **HOLD:**
  - `dec_valid` is held and the data stays stable until `dec_ready`.
  - On `dec_ready`: `dec_valid`<=0, then go to REQ.
- **DROP:**
  - Waits for the stale response. On `imem_rsp_valid` the data is discarded; go to REQ.
- **Branch:** highest priority in every state except IDLE.
  - `pc_out`<=`{branch_target[XLEN-1:2],2'b00}` and `dec_valid`<=0.
  - Next state depends on whether a response is still owed:
    - REQ with the handshake in the same cycle → DROP.
    - REQ without the handshake → REQ, with the new address.
    - WAIT without `imem_rsp_valid` → DROP.
    - WAIT with `imem_rsp_valid` → REQ; the response is discarded.
    - HOLD → REQ; the held instruction is squashed even if `dec_ready` is high.
    - DROP without `imem_rsp_valid` → DROP.
    - DROP with `imem_rsp_valid` → REQ.
  - The PC update never increments in a branch cycle.
- **Arithmetic:** the PC wraps modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 0.
- **Reset** at any state forces the reset values. An in-flight memory response arriving after reset is ignored, because IDLE/REQ do not sample `imem_rsp_valid`.
- `imem_req_addr` is stable while the request is pending, except on a branch cycle.

## Timing
- With reset deasserted before edge E0, `imem_req_valid` is high after E0.
- Zero-wait memory: request accepted at edge N, response at N+1, `dec_valid` high after N+1.
- Next request follows the `dec_ready` edge, so steady state is one instruction per 3 cycles.
- Branch-to-new-request latency is 1 cycle from REQ/HOLD/WAIT-with-response, and 1 cycle after the stale response from DROP.

## Configuration
- `FETCH_CTRL_EXC_EN` defined:
  - Adds input `exc_valid` (1 bit) and output `exc_taken` (1 bit).
  - `exc_valid` behaves exactly like a branch to `EXC_VECTOR`.
  - `exc_valid` has priority over a simultaneous `branch`.
  - `exc_taken` pulses the cycle after.
- Not defined: the ports are absent and exceptions do not exist.

## Structure
- **Shared package `fetch_pkg`:** state enum (IDLE, REQ, WAIT, HOLD, DROP), `INSTR_BYTES`=4, default `BOOT_ADDR`/`EXC_VECTOR` constants.
- **Sub-module `fetch_next_pc`:** combinational next-PC select (reset/exception/branch/increment/hold) with alignment masking.
- The FSM and output registers live in the top module.

## Test plan
- **Reset release, zero-wait memory, `dec_ready`=1:** `dec_pc` sequence 0x1000, 0x1004, 0x1008, one instruction every 3 cycles.
- **`dec_ready` low 5 cycles in HOLD:** `dec_valid`/`dec_instr` stable; no new request issued.
- **Branch to 0x2003 in WAIT, response 2 cycles later:** response dropped; next request addr 0x2000; first `dec_pc`=0x2000.
- **Branch in HOLD with `dec_ready`=1 same cycle:** instruction not consumed; next request addr=target.
- **PC=0xFFFF_FFFC accepted:** `pc_out` becomes 0; following request addr 0.
- **Reset asserted in WAIT, stale response on next cycle:** all outputs at reset values; stale data never reaches decode.
- **With `FETCH_CTRL_EXC_EN`, `exc_valid` and `branch` to 0x3000 in same cycle:** next request addr 0x0100; `exc_taken` pulses.
